// File: rtl/trap_fifo_pkg.sv
// Shared definitions for the trap capture FIFO: read-select codes, status bit
// positions and entry layout.
package trap_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int TS_W   = 8;
   localparam int CNT_W  = 5;

   localparam logic [2:0] SEL_STATUS  = 3'd0;
   localparam logic [2:0] SEL_PORT_LO = 3'd1;
   localparam logic [2:0] SEL_PORT_HI = 3'd2;
   localparam logic [2:0] SEL_DATA    = 3'd3;
   localparam logic [2:0] SEL_DIR     = 3'd4;
   localparam logic [2:0] SEL_TSTAMP  = 3'd5;

   localparam int ST_OVF   = 7;
   localparam int ST_FULL  = 6;
   localparam int ST_EMPTY = 5;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              dir;
      logic [DATA_W-1:0] data;
   } trap_entry_t;
endpackage

// File: rtl/trap_fifo_if.sv
// Bus-glue side signals of the trap FIFO: capture strobe/bus, hypervisor
// read/pop strobes and the outputs back to the mapper.
interface trap_fifo_if;
   import trap_pkg::*;
   logic              trap_addr_wr_n;
   logic [ADDR_W-1:0] addr_bus;
   logic              io_direction;
   logic [DATA_W-1:0] data_bus_in;
   logic              trap_rd_n;
   logic [2:0]        rd_sel;
   logic              pop_n;
   logic [DATA_W-1:0] data_out;
   logic              data_oe;
   logic              trap_pending;
   logic              overflow;

   modport master (
      output trap_addr_wr_n, addr_bus, io_direction, data_bus_in,
             trap_rd_n, rd_sel, pop_n,
      input  data_out, data_oe, trap_pending, overflow
   );
   modport slave (
      input  trap_addr_wr_n, addr_bus, io_direction, data_bus_in,
             trap_rd_n, rd_sel, pop_n,
      output data_out, data_oe, trap_pending, overflow
   );
endinterface

// File: rtl/trap_fifo_edge_sync.sv
// Synchronizer for an idle-high async strobe with a one-clk falling-edge pulse.
// Arms only after a real high has crossed the chain, so a strobe held low across reset never fires.
module trap_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_strobe_n,
   output logic o_fall
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] r_vld;
   logic                   r_hist;
   logic                   r_armed;
   logic                   w_sync_out;

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   // r_vld tracks how far real input samples have propagated since reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync  <= '1;
         r_vld   <= '0;
         r_hist  <= 1'b1;
         r_armed <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe_n};
         r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
         r_hist <= w_sync_out;
         if (&r_vld && w_sync_out)
            r_armed <= 1'b1;
      end
   end

   assign o_fall = r_armed & r_hist & ~w_sync_out;
endmodule

// File: rtl/trap_fifo.sv
// Trap capture FIFO: logs trapped I/O accesses for the hypervisor to drain.
// Optional TRAP_FIFO_TIMESTAMP_EN adds a per-entry 8-bit capture timestamp.
module trap_fifo
   import trap_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   trap_fifo_if.slave  bus
);
   localparam int               PW       = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic             w_push_ev, w_pop_ev;
   logic             w_do_push, w_do_pop;
   logic             w_empty, w_full;
   logic [PW-1:0]    r_head, r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf, r_pending;
   logic [TS_W-1:0]  w_head_ts;
   logic [7:0]       w_rdata;
   trap_entry_t      w_head;
   trap_entry_t      r_mem [DEPTH];

   trap_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trap_sync (
      .clk        (clk),
      .reset      (reset),
      .i_strobe_n (bus.trap_addr_wr_n),
      .o_fall     (w_push_ev)
   );

   trap_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pop_sync (
      .clk        (clk),
      .reset      (reset),
      .i_strobe_n (bus.pop_n),
      .o_fall     (w_pop_ev)
   );

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == FULL_CNT);
   assign w_do_pop  = w_pop_ev & ~w_empty;
   // A pop in the same clk frees the slot, so a push while full still lands
   assign w_do_push = w_push_ev & (~w_full | w_do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         if (w_do_push) r_tail <= r_tail + PW'(1);
         if (w_do_pop)  r_head <= r_head + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop_ev)
            r_ovf <= 1'b0;
         else if (w_push_ev && !w_do_push)
            r_ovf <= 1'b1;
         r_pending <= ~w_empty;
      end
   end

   // Entry storage is deliberately left without reset
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_tail] <= '{addr: bus.addr_bus, dir: bus.io_direction, data: bus.data_bus_in};
   end

`ifdef TRAP_FIFO_TIMESTAMP_EN
   logic [TS_W-1:0] r_ts;
   logic [TS_W-1:0] r_ts_mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_ts <= '0;
      else       r_ts <= r_ts + TS_W'(1);
   end

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_ts_mem[r_tail] <= r_ts;
   end

   assign w_head_ts = r_ts_mem[r_head];
`else
   assign w_head_ts = '0;
`endif

   assign w_head = r_mem[r_head];

   always_comb begin
      w_rdata = 8'h00;
      case (bus.rd_sel)
         SEL_STATUS: begin
            w_rdata           = {4'b0000, r_count[3:0]};
            w_rdata[ST_OVF]   = r_ovf;
            w_rdata[ST_FULL]  = w_full;
            w_rdata[ST_EMPTY] = w_empty;
         end
         SEL_PORT_LO: if (!w_empty) w_rdata = w_head.addr[7:0];
         SEL_PORT_HI: if (!w_empty) w_rdata = w_head.addr[15:8];
         SEL_DATA:    if (!w_empty) w_rdata = w_head.data;
         SEL_DIR:     if (!w_empty) w_rdata = {7'b0, w_head.dir};
         SEL_TSTAMP:  if (!w_empty) w_rdata = w_head_ts;
         default:     w_rdata = 8'h00;
      endcase
   end

   assign bus.data_out     = w_rdata;
   assign bus.data_oe      = ~bus.trap_rd_n;
   assign bus.trap_pending = r_pending;
   assign bus.overflow     = r_ovf;
endmodule

// File: tb/tb_trap_fifo.sv
// Directed bench for trap_fifo with a queue model of the expected FIFO contents.
// Define TRAP_FIFO_TIMESTAMP_EN for both bench and RTL to exercise timestamps.
module tb_trap_fifo;
   import trap_pkg::*;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int bad = 0;
   trap_entry_t q[$];
   logic exp_ovf = 1'b0;

   trap_fifo_if bus();

   trap_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [2:0] sel, output logic [7:0] v);
      bus.rd_sel = sel;
      bus.trap_rd_n = 1'b0;
      #1;
      v = bus.data_out;
      bus.trap_rd_n = 1'b1;
   endtask

   function automatic logic [7:0] exp_status();
      int n = q.size();
      return {exp_ovf, (n == DEPTH), (n == 0), 1'b0, 4'(n)};
   endfunction

   task automatic check_head(input string t);
      logic [7:0] v;
      trap_entry_t e;
      e = (q.size() > 0) ? q[0] : '0;
      rd(SEL_PORT_LO, v); chk({t, "_lo"}, v, e.addr[7:0]);
      rd(SEL_PORT_HI, v); chk({t, "_hi"}, v, e.addr[15:8]);
      rd(SEL_DATA, v);    chk({t, "_data"}, v, e.data);
      rd(SEL_DIR, v);     chk({t, "_dir"}, v, {7'b0, e.dir});
      rd(SEL_STATUS, v);  chk({t, "_status"}, v, exp_status());
      chk({t, "_pending"}, {7'b0, bus.trap_pending}, {7'b0, (q.size() != 0)});
      chk({t, "_ovf"}, {7'b0, bus.overflow}, {7'b0, exp_ovf});
   endtask

   task automatic model_push(input logic [15:0] a, input logic d, input logic [7:0] x);
      if (q.size() < DEPTH) q.push_back('{addr: a, dir: d, data: x});
      else exp_ovf = 1'b1;
   endtask

   task automatic trap(input logic [15:0] a, input logic d, input logic [7:0] x);
      @(negedge clk);
      bus.addr_bus = a; bus.io_direction = d; bus.data_bus_in = x;
      bus.trap_addr_wr_n = 1'b0;
      repeat (6) @(negedge clk);
      bus.trap_addr_wr_n = 1'b1;
      repeat (6) @(negedge clk);
      model_push(a, d, x);
   endtask

   task automatic pop(input string t);
      check_head(t);
      @(negedge clk);
      bus.pop_n = 1'b0;
      repeat (6) @(negedge clk);
      bus.pop_n = 1'b1;
      repeat (6) @(negedge clk);
      if (q.size() > 0) void'(q.pop_front());
      exp_ovf = 1'b0;
   endtask

   initial begin
      logic [7:0] v, t0, t1;
      bus.trap_addr_wr_n = 1'b1; bus.pop_n = 1'b1; bus.trap_rd_n = 1'b1;
      bus.rd_sel = 3'd0; bus.addr_bus = '0; bus.io_direction = 1'b0; bus.data_bus_in = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);

      // 1: reset state
      chk("t1_oe_idle", {7'b0, bus.data_oe}, 8'h00);
      bus.trap_rd_n = 1'b0; #1;
      chk("t1_oe_rd", {7'b0, bus.data_oe}, 8'h01);
      bus.trap_rd_n = 1'b1;
      rd(SEL_STATUS, v); chk("t1_status", v, 8'h20);
      rd(SEL_PORT_LO, v); chk("t1_lo", v, 8'h00);
      check_head("t1");

      // 2: single trap, with latency of trap_pending
      @(negedge clk);
      bus.addr_bus = 16'h12A5; bus.io_direction = 1'b1; bus.data_bus_in = 8'h3C;
      bus.trap_addr_wr_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("t2_pend_early", {7'b0, bus.trap_pending}, 8'h00);
      @(posedge clk);
      #1 chk("t2_pend_on", {7'b0, bus.trap_pending}, 8'h01);
      repeat (3) @(negedge clk);
      bus.trap_addr_wr_n = 1'b1;
      repeat (6) @(negedge clk);
      model_push(16'h12A5, 1'b1, 8'h3C);
      rd(SEL_PORT_LO, v); chk("t2_lo", v, 8'hA5);
      rd(SEL_PORT_HI, v); chk("t2_hi", v, 8'h12);
      rd(SEL_DATA, v);    chk("t2_data", v, 8'h3C);
      rd(SEL_DIR, v);     chk("t2_dir", v, 8'h01);
      rd(SEL_STATUS, v);  chk("t2_status", v, 8'h01);
      rd(3'd6, v);        chk("t2_sel6", v, 8'h00);
      rd(3'd7, v);        chk("t2_sel7", v, 8'h00);
      pop("t2_pop");
      check_head("t2_empty");

      // 3: overflow on the fifth trap, drained in order
      for (int i = 1; i <= 5; i++) trap(16'(i), 1'(i), 8'(8'h40 + i));
      rd(SEL_STATUS, v); chk("t3_status", v, 8'hC4);
      chk("t3_ovf", {7'b0, bus.overflow}, 8'h01);
      for (int i = 1; i <= 4; i++) begin
         rd(SEL_PORT_LO, v); chk("t3_order", v, 8'(i));
         pop("t3_pop");
         if (i == 1) chk("t3_ovf_clr", {7'b0, bus.overflow}, 8'h00);
      end
      rd(SEL_STATUS, v); chk("t3_drained", v, 8'h20);

      // 4: simultaneous push and pop while full
      for (int i = 0; i < 4; i++) trap(16'(8'h10 + i), 1'b0, 8'(8'h80 + i));
      @(negedge clk);
      bus.addr_bus = 16'h0014; bus.io_direction = 1'b1; bus.data_bus_in = 8'h94;
      bus.trap_addr_wr_n = 1'b0; bus.pop_n = 1'b0;
      repeat (6) @(negedge clk);
      bus.trap_addr_wr_n = 1'b1; bus.pop_n = 1'b1;
      repeat (6) @(negedge clk);
      void'(q.pop_front());
      model_push(16'h0014, 1'b1, 8'h94);
      exp_ovf = 1'b0;
      rd(SEL_STATUS, v);  chk("t4_status", v, 8'h44);
      rd(SEL_PORT_LO, v); chk("t4_head", v, 8'h11);
      for (int i = 0; i < 3; i++) pop("t4_pop");
      rd(SEL_PORT_LO, v); chk("t4_tail", v, 8'h14);

      // 5: reset while the strobe is low discards the event
      @(negedge clk);
      bus.addr_bus = 16'h0BAD; bus.trap_addr_wr_n = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      q.delete(); exp_ovf = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      rd(SEL_STATUS, v); chk("t5_dropped", v, 8'h20);
      check_head("t5_empty");
      bus.trap_addr_wr_n = 1'b1;
      repeat (6) @(negedge clk);
      trap(16'h0042, 1'b0, 8'h99);
      rd(SEL_PORT_LO, v); chk("t5_rec_lo", v, 8'h42);
      rd(SEL_STATUS, v);  chk("t5_rec_status", v, 8'h01);
      pop("t5_pop");

      // 6: timestamps ten clks apart, or zero when not built
`ifdef TRAP_FIFO_TIMESTAMP_EN
      @(negedge clk);
      bus.addr_bus = 16'h00A1; bus.io_direction = 1'b0; bus.data_bus_in = 8'h01;
      bus.trap_addr_wr_n = 1'b0;
      repeat (5) @(negedge clk);
      bus.trap_addr_wr_n = 1'b1;
      repeat (5) @(negedge clk);
      bus.addr_bus = 16'h00A2; bus.data_bus_in = 8'h02;
      bus.trap_addr_wr_n = 1'b0;
      repeat (6) @(negedge clk);
      bus.trap_addr_wr_n = 1'b1;
      repeat (6) @(negedge clk);
      model_push(16'h00A1, 1'b0, 8'h01);
      model_push(16'h00A2, 1'b0, 8'h02);
      rd(SEL_TSTAMP, t0);
      pop("t6_pop_a");
      rd(SEL_TSTAMP, t1);
      chk("t6_ts_delta", t1 - t0, 8'd10);
      pop("t6_pop_b");
`else
      trap(16'h00A1, 1'b0, 8'h01);
      rd(SEL_TSTAMP, v); chk("t6_ts_zero", v, 8'h00);
      pop("t6_pop");
`endif
      check_head("t6_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
